// File: rtl/mips_multi_controller_v2_if.sv
// Bus between the multicycle MIPS controller and its datapath/memory port.
// master = controller side, slave = datapath/memory side.
// The trap signal exists only when MIPS_MULTI_CTRL_TRAP_EN is defined.
interface mips_multi_controller_v2_if #(
  parameter int ALUCTL_W = 3
);
  // datapath / memory -> controller
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  // controller -> datapath / memory
  logic                mem_req;
  logic                pc_en;
  logic                i_or_d;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alusrc_A;
  logic [1:0]          alusrc_B;
  logic [ALUCTL_W-1:0] alu_control;
  logic [1:0]          pc_src;
  logic [3:0]          state_o;
  logic                mem_timeout;
`ifdef MIPS_MULTI_CTRL_TRAP_EN
  logic                trap;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alusrc_A, alusrc_B, alu_control, pc_src, state_o,
           mem_timeout, trap
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alusrc_A, alusrc_B, alu_control, pc_src, state_o,
           mem_timeout, trap
  );
`else
  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alusrc_A, alusrc_B, alu_control, pc_src, state_o,
           mem_timeout
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alusrc_A, alusrc_B, alu_control, pc_src, state_o,
           mem_timeout
  );
`endif
endinterface

// File: rtl/mips_multi_controller_v2.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, bne, addi, j) with a
// mem_ready wait-state handshake and an optional wait timeout (TIMEOUT>0).
// Optional feature macro: MIPS_MULTI_CTRL_TRAP_EN adds a TRAP state that
// catches undefined opcodes and unknown R-type functs.
module mips_multi_controller_v2 #(
  parameter int ALUCTL_W = 3,
  parameter int TIMEOUT  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_multi_controller_v2_if.master  bus
);
  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                         S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_BEQ    = 4'd8,
                         S_BNE    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_JUMP   = 4'd12, S_TRAP   = 4'd13;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR  = 3'b001, ALU_SLT = 3'b111;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             waiting, timeout;
  logic [2:0]       funct_alu;
  logic             funct_known;

  // Strobes before reset/timeout gating
  logic pc_write, branch, branch_ne, mem_req, i_or_d, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, alusrc_a, trap;
  logic [1:0] alusrc_b, pc_src;
  logic [2:0] alu3;
  logic [ALUCTL_W-1:0] alu_ext;
  logic pc_en_o, ir_write_o, mem_write_o, reg_write_o, mem_req_o, timeout_o;

  // State and wait counter, asynchronously forced to FETCH / 0 by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Memory wait tracking: abort once TIMEOUT consecutive unready cycles pass
  always_comb begin
    waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout = (TIMEOUT > 0) && waiting && (wait_q == CNT_W'(TIMEOUT));
    wait_d  = '0;
    if ((TIMEOUT > 0) && waiting && !bus.mem_ready && !timeout && (state_d == state_q))
      wait_d = wait_q + CNT_W'(1);
  end

  // R-type funct decode into the 3-bit ALU code
  always_comb begin
    funct_known = 1'b1;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default: begin
        funct_alu   = ALU_ADD;
        funct_known = 1'b0;
      end
    endcase
  end

  // Next-state logic; a timeout abort always restarts at FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000000:            state_d = S_EXEC;
          6'b000100:            state_d = S_BEQ;
          6'b000101:            state_d = S_BNE;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JUMP;
`ifdef MIPS_MULTI_CTRL_TRAP_EN
          default:              state_d = S_TRAP;
`else
          default:              state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (bus.op == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
`ifdef MIPS_MULTI_CTRL_TRAP_EN
      S_EXEC:   state_d = funct_known ? S_ALUWB : S_TRAP;
      S_TRAP:   state_d = S_TRAP;
`else
      S_EXEC:   state_d = S_ALUWB;
`endif
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // Moore strobe decode, then FETCH/timeout/reset gating of the write strobes
  always_comb begin
    pc_write = 1'b0; branch = 1'b0; branch_ne = 1'b0; mem_req = 1'b0;
    i_or_d = 1'b0; mem_write = 1'b0; ir_write = 1'b0; reg_dst = 1'b0;
    mem_to_reg = 1'b0; reg_write = 1'b0; alusrc_a = 1'b0; trap = 1'b0;
    alusrc_b = 2'b00; pc_src = 2'b00; alu3 = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1; alusrc_b = 2'b01; alu3 = ALU_ADD;
        ir_write = bus.mem_ready; pc_write = bus.mem_ready;
      end
      S_DECODE: begin alusrc_b = 2'b11; alu3 = ALU_ADD; end
      S_MEMADR: begin alusrc_a = 1'b1; alusrc_b = 2'b10; alu3 = ALU_ADD; end
      S_MEMRD:  begin mem_req = 1'b1; i_or_d = 1'b1; end
      S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:  begin mem_req = 1'b1; i_or_d = 1'b1; mem_write = 1'b1; end
      S_EXEC:   begin alusrc_a = 1'b1; alu3 = funct_alu; end
      S_ALUWB:  begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BEQ:    begin alusrc_a = 1'b1; alu3 = ALU_SUB; pc_src = 2'b01; branch = 1'b1; end
      S_BNE:    begin alusrc_a = 1'b1; alu3 = ALU_SUB; pc_src = 2'b01; branch_ne = 1'b1; end
      S_ADDIEX: begin alusrc_a = 1'b1; alusrc_b = 2'b10; alu3 = ALU_ADD; end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP:   begin pc_src = 2'b10; pc_write = 1'b1; end
      S_TRAP:   trap = 1'b1;
      default:  ;
    endcase
    // An aborted access neither requests memory nor commits anything
    if (timeout) begin
      mem_req = 1'b0; mem_write = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
    end
    pc_en_o     = !reset && (pc_write || (branch && bus.zero) || (branch_ne && !bus.zero));
    ir_write_o  = !reset && ir_write;
    mem_write_o = !reset && mem_write;
    reg_write_o = !reset && reg_write;
    mem_req_o   = !reset && mem_req;
    timeout_o   = !reset && timeout;
    alu_ext      = '0;
    alu_ext[2:0] = alu3;
  end

  assign bus.pc_en       = pc_en_o;
  assign bus.ir_write    = ir_write_o;
  assign bus.mem_write   = mem_write_o;
  assign bus.reg_write   = reg_write_o;
  assign bus.mem_req     = mem_req_o;
  assign bus.mem_timeout = timeout_o;
  assign bus.i_or_d      = i_or_d;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.alusrc_A    = alusrc_a;
  assign bus.alusrc_B    = alusrc_b;
  assign bus.alu_control = alu_ext;
  assign bus.pc_src      = pc_src;
  assign bus.state_o     = state_q;
`ifdef MIPS_MULTI_CTRL_TRAP_EN
  assign bus.trap        = trap;
`else
  logic unused_trap;
  assign unused_trap = trap;
`endif
endmodule

// File: tb/tb_mips_multi_controller_v2.sv
// Directed bench for mips_multi_controller_v2 (ALUCTL_W=4, TIMEOUT=4).
module tb_mips_multi_controller_v2;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mips_multi_controller_v2_if #(.ALUCTL_W(4)) bus_if ();

  mips_multi_controller_v2 #(.ALUCTL_W(4), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock; sample point is 2 time units after the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // From a FETCH sample point: fetch and decode one instruction with no wait
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] funct);
    bus_if.op = op;
    bus_if.funct = funct;
    bus_if.mem_ready = 1'b1;
    #1;
    check_eq("fetch_state", 32'(bus_if.state_o), 32'd0);
    check_eq("fetch_ir_write", 32'(bus_if.ir_write), 32'd1);
    step();
    check_eq("decode_state", 32'(bus_if.state_o), 32'd1);
    check_eq("decode_alusrc_B", 32'(bus_if.alusrc_B), 32'd3);
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus_if.op = OP_LW;
    bus_if.funct = 6'd0;
    bus_if.zero = 1'b0;
    bus_if.mem_ready = 1'b1;
    #2;
    check_eq("rst_state", 32'(bus_if.state_o), 32'd0);
    check_eq("rst_ir_write", 32'(bus_if.ir_write), 32'd0);
    check_eq("rst_pc_en", 32'(bus_if.pc_en), 32'd0);
    check_eq("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    check_eq("rst_alusrc_B", 32'(bus_if.alusrc_B), 32'd1);
    check_eq("rst_alu", 32'(bus_if.alu_control), 32'h2);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // lw: 0,1,2,3,4 then back to 0
    check_eq("lw_fetch_pc_en", 32'(bus_if.pc_en), 32'd1);
    check_eq("lw_fetch_mem_req", 32'(bus_if.mem_req), 32'd1);
    fetch_decode(OP_LW, 6'd0);
    check_eq("lw_memadr_state", 32'(bus_if.state_o), 32'd2);
    check_eq("lw_memadr_alusrc_B", 32'(bus_if.alusrc_B), 32'd2);
    check_eq("lw_memadr_reg_write", 32'(bus_if.reg_write), 32'd0);
    step();
    check_eq("lw_memrd_state", 32'(bus_if.state_o), 32'd3);
    check_eq("lw_memrd_i_or_d", 32'(bus_if.i_or_d), 32'd1);
    check_eq("lw_memrd_reg_write", 32'(bus_if.reg_write), 32'd0);
    step();
    check_eq("lw_memwb_state", 32'(bus_if.state_o), 32'd4);
    check_eq("lw_memwb_reg_write", 32'(bus_if.reg_write), 32'd1);
    check_eq("lw_memwb_mem_to_reg", 32'(bus_if.mem_to_reg), 32'd1);
    step();
    check_eq("lw_done_state", 32'(bus_if.state_o), 32'd0);

    // R-type sub, slt, unknown funct
    fetch_decode(OP_R, 6'b100010);
    check_eq("sub_exec_state", 32'(bus_if.state_o), 32'd6);
    check_eq("sub_exec_alu", 32'(bus_if.alu_control), 32'h6);
    check_eq("sub_exec_alusrc_A", 32'(bus_if.alusrc_A), 32'd1);
    step();
    check_eq("sub_aluwb_state", 32'(bus_if.state_o), 32'd7);
    check_eq("sub_aluwb_reg_dst", 32'(bus_if.reg_dst), 32'd1);
    check_eq("sub_aluwb_reg_write", 32'(bus_if.reg_write), 32'd1);
    step();
    check_eq("sub_done_state", 32'(bus_if.state_o), 32'd0);
    fetch_decode(OP_R, 6'b101010);
    check_eq("slt_exec_alu", 32'(bus_if.alu_control), 32'h7);
    step(); step();
    fetch_decode(OP_R, 6'b100101);
    check_eq("or_exec_alu", 32'(bus_if.alu_control), 32'h1);
    step(); step();
    fetch_decode(OP_R, 6'b111111);
    check_eq("badfunct_exec_alu", 32'(bus_if.alu_control), 32'h2);
    step();
    check_eq("badfunct_aluwb_state", 32'(bus_if.state_o), 32'd7);
    step();

    // Branches
    bus_if.zero = 1'b1;
    fetch_decode(OP_BEQ, 6'd0);
    check_eq("beq_z1_state", 32'(bus_if.state_o), 32'd8);
    check_eq("beq_z1_pc_en", 32'(bus_if.pc_en), 32'd1);
    check_eq("beq_z1_pc_src", 32'(bus_if.pc_src), 32'd1);
    check_eq("beq_z1_alu", 32'(bus_if.alu_control), 32'h6);
    step();
    fetch_decode(OP_BNE, 6'd0);
    check_eq("bne_z1_state", 32'(bus_if.state_o), 32'd9);
    check_eq("bne_z1_pc_en", 32'(bus_if.pc_en), 32'd0);
    step();
    bus_if.zero = 1'b0;
    fetch_decode(OP_BNE, 6'd0);
    check_eq("bne_z0_pc_en", 32'(bus_if.pc_en), 32'd1);
    step();
    fetch_decode(OP_BEQ, 6'd0);
    check_eq("beq_z0_pc_en", 32'(bus_if.pc_en), 32'd0);
    step();

    // addi and j
    fetch_decode(OP_ADDI, 6'd0);
    check_eq("addi_ex_state", 32'(bus_if.state_o), 32'd10);
    check_eq("addi_ex_alusrc_B", 32'(bus_if.alusrc_B), 32'd2);
    step();
    check_eq("addi_wb_state", 32'(bus_if.state_o), 32'd11);
    check_eq("addi_wb_reg_write", 32'(bus_if.reg_write), 32'd1);
    check_eq("addi_wb_reg_dst", 32'(bus_if.reg_dst), 32'd0);
    step();
    fetch_decode(OP_J, 6'd0);
    check_eq("j_state", 32'(bus_if.state_o), 32'd12);
    check_eq("j_pc_en", 32'(bus_if.pc_en), 32'd1);
    check_eq("j_pc_src", 32'(bus_if.pc_src), 32'd2);
    step();

    // Undefined opcode returns to FETCH
    fetch_decode(OP_BAD, 6'd0);
    check_eq("badop_state", 32'(bus_if.state_o), 32'd0);

    // Fetch wait states: 3 unready cycles, then ready
    bus_if.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("fwait_state", 32'(bus_if.state_o), 32'd0);
      check_eq("fwait_ir_write", 32'(bus_if.ir_write), 32'd0);
      check_eq("fwait_pc_en", 32'(bus_if.pc_en), 32'd0);
      check_eq("fwait_mem_req", 32'(bus_if.mem_req), 32'd1);
      step();
    end
    bus_if.mem_ready = 1'b1;
    #1;
    check_eq("fwait_go_ir_write", 32'(bus_if.ir_write), 32'd1);
    check_eq("fwait_go_pc_en", 32'(bus_if.pc_en), 32'd1);
    check_eq("fwait_go_timeout", 32'(bus_if.mem_timeout), 32'd0);
    step();
    check_eq("fwait_decode_state", 32'(bus_if.state_o), 32'd1);
    step();
    check_eq("fwait_back_state", 32'(bus_if.state_o), 32'd0);

    // sw with mem_ready stuck low: 4 write cycles, then timeout abort
    fetch_decode(OP_SW, 6'd0);
    check_eq("sw_memadr_state", 32'(bus_if.state_o), 32'd2);
    bus_if.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("swto_state", 32'(bus_if.state_o), 32'd5);
      check_eq("swto_mem_write", 32'(bus_if.mem_write), 32'd1);
      check_eq("swto_no_timeout", 32'(bus_if.mem_timeout), 32'd0);
      step();
    end
    check_eq("swto_abort_state", 32'(bus_if.state_o), 32'd5);
    check_eq("swto_abort_timeout", 32'(bus_if.mem_timeout), 32'd1);
    check_eq("swto_abort_mem_write", 32'(bus_if.mem_write), 32'd0);
    check_eq("swto_abort_mem_req", 32'(bus_if.mem_req), 32'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      check_eq("swto_after_state", 32'(bus_if.state_o), 32'd0);
      check_eq("swto_after_mem_write", 32'(bus_if.mem_write), 32'd0);
      check_eq("swto_after_timeout", 32'(bus_if.mem_timeout), 32'd0);
      step();
    end

    // Reset in the middle of a waiting sw
    fetch_decode(OP_SW, 6'd0);
    bus_if.mem_ready = 1'b0;
    step();
    step();
    check_eq("swrst_pre_mem_write", 32'(bus_if.mem_write), 32'd1);
    check_eq("swrst_pre_count", 32'(dut.wait_q), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("swrst_mem_write", 32'(bus_if.mem_write), 32'd0);
    check_eq("swrst_state", 32'(bus_if.state_o), 32'd0);
    check_eq("swrst_count", 32'(dut.wait_q), 32'd0);
    check_eq("swrst_mem_req", 32'(bus_if.mem_req), 32'd0);
    #1 reset = 1'b0;
    step();
    check_eq("swrst_after_state", 32'(bus_if.state_o), 32'd0);
    check_eq("swrst_after_mem_write", 32'(bus_if.mem_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_multi_controller_v2.md
Name: mips_multi_controller_v2

Overview:
Second-generation multicycle MIPS control unit: one FSM that drives the datapath control strobes for fetch, decode, execute, memory and writeback. It extends the first-generation controller with bne, addi and j, a memory ready/request handshake that inserts wait states, and an optional memory-timeout counter. It sits between the instruction register, the memory port and the multicycle datapath.

Parameters:
ALUCTL_W, 3, alu_control width (minimum 3); upper bits above bit 2 are driven 0.
TIMEOUT, 0, maximum cycles waiting for mem_ready before abort; 0 disables the timeout counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
op  in  6  instruction opcode field
funct  in  6  instruction funct field
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
pc_en  out  1  PC load enable
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=Data
reg_write  out  1  register file write
alusrc_A  out  1  ALU A: 0=PC, 1=A
alusrc_B  out  2  ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
alu_control  out  ALUCTL_W  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
state_o  out  4  current state code, debug only
mem_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- State register updates on the rising clk edge. Reset is asynchronous: the state goes to FETCH and the wait counter clears.
- While reset is high, pc_en, ir_write, mem_write, reg_write, mem_req and mem_timeout are 0. The other outputs take their FETCH values.
- Outputs are Moore, decoded from the state only, except:
  - pc_en = pc_write | (branch & zero) | (branch_ne & ~zero).
  - FETCH strobes are gated by mem_ready.
- Any strobe not listed for a state is 0.
- States and strobes:
  - FETCH (0): mem_req=1, i_or_d=0, alusrc_A=0, alusrc_B=01, alu add, pc_src=00. ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE (1): alusrc_A=0, alusrc_B=11, alu add. Dispatch on op: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 000101 -> BNE; 001000 -> ADDIEX; 000010 -> JUMP; any other op -> FETCH.
  - MEMADR (2): alusrc_A=1, alusrc_B=10, add. lw -> MEMRD; sw -> MEMWR.
  - MEMRD (3): mem_req=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
  - MEMWR (5): mem_req=1, i_or_d=1, mem_write=1. mem_write stays high while waiting. On mem_ready goes to FETCH.
  - EXEC (6): alusrc_A=1, alusrc_B=00, alu from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other funct -> 010 (add). Next state ALUWB.
  - ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
  - BEQ (8): alusrc_A=1, alusrc_B=00, sub, pc_src=01, branch=1. Next state FETCH.
  - BNE (9): same as BEQ but branch_ne=1. Next state FETCH.
  - ADDIEX (10): alusrc_A=1, alusrc_B=10, add. Next state ADDIWB.
  - ADDIWB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
  - JUMP (12): pc_src=10, pc_write=1. Next state FETCH.
- Latencies with zero wait (mem_ready held high): R-type/addi 4 cycles, lw 5, sw 4, beq/bne/j 3.
- Wait counter:
  - Counts consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready or on any state change.
  - TIMEOUT>0 and count reaches TIMEOUT: pulse mem_timeout for 1 cycle; next state FETCH; mem_req drops for that cycle; no write strobe.
  - TIMEOUT=0: the controller waits indefinitely.
- Reset mid-operation: strobes drop immediately (asynchronously). A partially done sw produces no further mem_write.

Optional Feature:
Macro MIPS_MULTI_CTRL_TRAP_EN.
- Defined: adds state TRAP (13) and output trap (1 bit).
  - An undefined op in DECODE, or a funct outside the table in EXEC, goes to TRAP.
  - TRAP holds trap=1 with all strobes 0 until reset; EXEC performs no register write.
- Undefined: no trap port. An undefined op returns to FETCH; an unknown funct executes as add.

Test Plan:
- Reset high then low, op=lw, mem_ready always 1 -> states 0,1,2,3,4,0 over 5 cycles; reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type funct=100010 -> alu_control=110 in EXEC; ALUWB has reg_dst=1, reg_write=1; 4 cycles total.
- beq with zero=1 -> pc_en=1, pc_src=01 in state 8. bne with zero=1 -> pc_en=0. bne with zero=0 -> pc_en=1.
- Fetch with mem_ready held 0 for 3 cycles then 1 -> ir_write and pc_en 0 for 3 cycles, 1 in cycle 4, then DECODE.
- TIMEOUT=4, sw with mem_ready stuck 0 -> mem_write high 4 cycles, mem_timeout pulse, return to FETCH, no further mem_write.
- Assert reset during MEMWR -> mem_write falls same cycle (async), state_o=0, counter 0.
